// File: rtl/ex.sv
// Execute stage: logic, shift and arithmetic ALU with single-cycle multiply
// and an iterative radix-2 restoring divider that stalls the front end.

`ifndef ALUOpWidth
`define ALUOpWidth 8
`endif
`ifndef ALUSelWidth
`define ALUSelWidth 3
`endif

module ex (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`ALUOpWidth-1:0]  aluop_i,
    input  logic [`ALUSelWidth-1:0] alusel_i,
    input  logic [31:0]             reg1_i,
    input  logic [31:0]             reg2_i,
    input  logic [4:0]              reg_write_addr_i,
    input  logic                    reg_write_en_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    reg_write_en_o,
    output logic [4:0]              reg_write_addr_o,
    output logic [31:0]             reg_write_data_o,
    output logic                    pause_ex
);

    localparam logic [`ALUSelWidth-1:0] SEL_NOP   = 3'd0;
    localparam logic [`ALUSelWidth-1:0] SEL_LOGIC = 3'd1;
    localparam logic [`ALUSelWidth-1:0] SEL_SHIFT = 3'd2;
    localparam logic [`ALUSelWidth-1:0] SEL_ARITH = 3'd3;

    localparam logic [`ALUOpWidth-1:0] OP_OR     = 8'h01;
    localparam logic [`ALUOpWidth-1:0] OP_ORI    = 8'h02;
    localparam logic [`ALUOpWidth-1:0] OP_AND    = 8'h03;
    localparam logic [`ALUOpWidth-1:0] OP_NOR    = 8'h04;
    localparam logic [`ALUOpWidth-1:0] OP_XOR    = 8'h05;
    localparam logic [`ALUOpWidth-1:0] OP_SLLW   = 8'h10;
    localparam logic [`ALUOpWidth-1:0] OP_SLLIW  = 8'h11;
    localparam logic [`ALUOpWidth-1:0] OP_SRLW   = 8'h12;
    localparam logic [`ALUOpWidth-1:0] OP_SRLIW  = 8'h13;
    localparam logic [`ALUOpWidth-1:0] OP_SRAW   = 8'h14;
    localparam logic [`ALUOpWidth-1:0] OP_SRAIW  = 8'h15;
    localparam logic [`ALUOpWidth-1:0] OP_ADDW   = 8'h20;
    localparam logic [`ALUOpWidth-1:0] OP_SUBW   = 8'h21;
    localparam logic [`ALUOpWidth-1:0] OP_SLT    = 8'h22;
    localparam logic [`ALUOpWidth-1:0] OP_SLTU   = 8'h23;
    localparam logic [`ALUOpWidth-1:0] OP_MULW   = 8'h24;
    localparam logic [`ALUOpWidth-1:0] OP_MULHW  = 8'h25;
    localparam logic [`ALUOpWidth-1:0] OP_MULHWU = 8'h26;
    localparam logic [`ALUOpWidth-1:0] OP_DIVW   = 8'h28;
    localparam logic [`ALUOpWidth-1:0] OP_MODW   = 8'h29;
    localparam logic [`ALUOpWidth-1:0] OP_DIVWU  = 8'h2A;
    localparam logic [`ALUOpWidth-1:0] OP_MODWU  = 8'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t  state;
    div_state_t  state_next;

    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [4:0]  cnt;
    logic        quot_neg;
    logic        rem_neg;
    logic        is_mod;

    logic        div_op;
    logic        div_signed;
    logic        div_start;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] div_result;

    logic [63:0] prod_s;
    logic [31:0] mulhu;
    logic [31:0] alu_result;

    // Decode divide requests and operand magnitudes for the divider
    always_comb begin
        div_op     = (alusel_i == SEL_ARITH) &&
                     (aluop_i inside {OP_DIVW, OP_MODW, OP_DIVWU, OP_MODWU});
        div_signed = (aluop_i == OP_DIVW) || (aluop_i == OP_MODW);
        div_start  = (state == IDLE) && div_op && !flush_i;
        mag1       = (div_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
        mag2       = (div_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
        rem_shift  = {remainder, dividend[31]};
        diff       = rem_shift - {1'b0, divisor};
    end

    // Divider state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Divider next-state: flush overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (div_start) state_next = (reg2_i == '0) ? DONE : BUSY;
            BUSY: if (cnt == 5'd31) state_next = DONE;
            DONE: if (!stall_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    // Divider datapath: latch operands on start, one restoring step per BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend  <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            quot_neg  <= 1'b0;
            rem_neg   <= 1'b0;
            is_mod    <= 1'b0;
        end else if (div_start) begin
            is_mod <= (aluop_i == OP_MODW) || (aluop_i == OP_MODWU);
            cnt    <= '0;
            if (reg2_i == '0) begin
                // Divide by zero bypasses iteration; remainder is the raw dividend
                quotient  <= '1;
                remainder <= reg1_i;
                quot_neg  <= 1'b0;
                rem_neg   <= 1'b0;
            end else begin
                dividend  <= mag1;
                divisor   <= mag2;
                quotient  <= '0;
                remainder <= '0;
                quot_neg  <= div_signed && (reg1_i[31] ^ reg2_i[31]);
                rem_neg   <= div_signed && reg1_i[31];
            end
        end else if (state == BUSY && !flush_i) begin
            dividend <= {dividend[30:0], 1'b0};
            cnt      <= cnt + 5'd1;
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= rem_shift[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
        end
    end

    // Signed fix-up of the unsigned divider result
    always_comb begin
        if (is_mod) div_result = rem_neg  ? (~remainder + 32'd1) : remainder;
        else        div_result = quot_neg ? (~quotient + 32'd1)  : quotient;
    end

    // Single-cycle ALU; unsigned high product derived from the signed one
    always_comb begin
        prod_s     = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
        mulhu      = prod_s[63:32] + (reg1_i[31] ? reg2_i : 32'd0) + (reg2_i[31] ? reg1_i : 32'd0);
        alu_result = '0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_OR, OP_ORI: alu_result = reg1_i | reg2_i;
                    OP_AND:        alu_result = reg1_i & reg2_i;
                    OP_NOR:        alu_result = ~(reg1_i | reg2_i);
                    OP_XOR:        alu_result = reg1_i ^ reg2_i;
                    default:       alu_result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLLW, OP_SLLIW: alu_result = reg1_i << reg2_i[4:0];
                    OP_SRLW, OP_SRLIW: alu_result = reg1_i >> reg2_i[4:0];
                    OP_SRAW, OP_SRAIW: alu_result = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
                    default:           alu_result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDW:   alu_result = reg1_i + reg2_i;
                    OP_SUBW:   alu_result = reg1_i - reg2_i;
                    OP_SLT:    alu_result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    OP_SLTU:   alu_result = {31'd0, reg1_i < reg2_i};
                    OP_MULW:   alu_result = prod_s[31:0];
                    OP_MULHW:  alu_result = prod_s[63:32];
                    OP_MULHWU: alu_result = mulhu;
                    default:   alu_result = '0;
                endcase
            end
            SEL_NOP: alu_result = '0;
            default: alu_result = '0;
        endcase
    end

    // Output mux; everything is held at zero while reset is asserted
    always_comb begin
        pause_ex         = rst && div_op && (state != DONE);
        reg_write_en_o   = rst && reg_write_en_i && !flush_i && !pause_ex;
        reg_write_addr_o = rst ? reg_write_addr_i : 5'd0;
        reg_write_data_o = '0;
        if (rst) begin
            if (div_op) reg_write_data_o = (state == DONE) ? div_result : 32'd0;
            else        reg_write_data_o = alu_result;
        end
    end

endmodule
